// File: rtl/core_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : core_bus_arbiter
//  Description : Shares one memory bus port between NREQ requesters.
//                Requesters are served round-robin. Responses come back in
//                order and are routed to the requester that issued them,
//                using a FIFO of requester IDs, one entry per accepted request.
//  Revision    : 1.0  initial release
// ============================================================================
module core_bus_arbiter #(
    parameter int NREQ  = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*AW-1:0]     addr,
    input  logic [NREQ*DW-1:0]     wdata,
    input  logic [NREQ*DW/8-1:0]   bytemask,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DW-1:0]          rdata,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic [DW/8-1:0]        mem_bytemask,
    input  logic                   mem_ready,
    input  logic                   mem_rvalid,
    input  logic [DW-1:0]          mem_rdata,
    output logic                   err
);

    localparam int c_id_w = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_pw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw   = $clog2(DEPTH + 1);
    localparam int c_bw   = DW / 8;

    logic [c_id_w-1:0] r_rr_ptr;
    logic [c_id_w-1:0] r_fifo [DEPTH];
    logic [c_pw-1:0]   r_wr_ptr;
    logic [c_pw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;
    logic              r_err;

    logic [c_id_w:0]   w_cand;
    logic              w_found;
    logic [c_id_w-1:0] w_winner;
    logic [c_id_w-1:0] w_head;
    logic              w_pop;
    logic              w_can_accept;
    logic              w_mem_req;
    logic              w_accept;

    // Round-robin winner: first requester at or after r_rr_ptr, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (c_id_w+1)'(k);
            if (w_cand >= (c_id_w+1)'(NREQ)) begin
                w_cand = w_cand - (c_id_w+1)'(NREQ);
            end
            if (!w_found && req[w_cand[c_id_w-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[c_id_w-1:0];
            end
        end
    end

    // A response arriving this cycle frees a slot, so a full FIFO can still accept
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_pop        = rst & mem_rvalid & (r_count != '0);
    assign w_can_accept = (r_count < c_cw'(DEPTH)) | w_pop;
    assign w_mem_req    = rst & w_found & w_can_accept;
    assign w_accept     = w_mem_req & mem_ready;

    assign mem_req = w_mem_req;
    assign rdata   = mem_rdata;
    assign err     = r_err;

    // Downstream request fields come from the winner's slice, zero when idle
    always_comb begin
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_bytemask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_mem_req && (w_winner == c_id_w'(i))) begin
                mem_we       = we[i];
                mem_addr     = addr[i*AW +: AW];
                mem_wdata    = wdata[i*DW +: DW];
                mem_bytemask = bytemask[i*c_bw +: c_bw];
            end
        end
    end

    // One-hot grant to the winner and one-hot response to the FIFO head
    always_comb begin
        gnt    = '0;
        rvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i]    = w_accept && (w_winner == c_id_w'(i));
            rvalid[i] = w_pop && (w_head == c_id_w'(i));
        end
    end

    // ID storage needs no reset: occupancy is tracked by r_count and the pointers
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= w_winner;
        end
    end

    // Priority pointer, FIFO pointers, occupancy and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= (w_winner == c_id_w'(NREQ-1)) ? '0 : w_winner + c_id_w'(1);
                r_wr_ptr <= (r_wr_ptr == c_pw'(DEPTH-1)) ? '0 : r_wr_ptr + c_pw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_pw'(DEPTH-1)) ? '0 : r_rd_ptr + c_pw'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + c_cw'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - c_cw'(1);
            end
            if (mem_rvalid && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_bus_arbiter
//  Description : Directed, table-driven bench for core_bus_arbiter
//                (NREQ=2, DEPTH=4) plus hand-written reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_core_bus_arbiter;

    localparam int NREQ  = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NVEC  = 25;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      we;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ*DW/8-1:0] bytemask;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [DW-1:0]        rdata;
    logic                 mem_req;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW/8-1:0]      mem_bytemask;
    logic                 mem_ready;
    logic                 mem_rvalid;
    logic [DW-1:0]        mem_rdata;
    logic                 err;

    int errors = 0;
    int checks = 0;

    core_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .bytemask(bytemask), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_bytemask(mem_bytemask),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] addr1;
        logic        ready;
        logic        mrv;
        logic [31:0] mrdata;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rvalid;
        logic        e_mreq;
        logic [31:0] e_addr;
        logic        e_we;
        logic        e_err;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [1:0] r, input logic [31:0] a1,
                                input logic rdy, input logic mrv,
                                input logic [31:0] md, input logic [1:0] eg,
                                input logic [1:0] erv, input logic emr,
                                input logic [31:0] ea, input logic ewe,
                                input logic eerr);
        vec_t v;
        v.req = r; v.addr1 = a1; v.ready = rdy; v.mrv = mrv; v.mrdata = md;
        v.e_gnt = eg; v.e_rvalid = erv; v.e_mreq = emr; v.e_addr = ea;
        v.e_we = ewe; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [31:0] a1, input logic rdy,
                         input logic mrv, input logic [31:0] md);
        req        = r;
        addr       = {a1, 32'h0000_1000};
        mem_ready  = rdy;
        mem_rvalid = mrv;
        mem_rdata  = md;
    endtask

    initial begin
        // reset / contention
        vecs[0]  = mk(2'b11, 32'h2000, 1, 0, 0,     2'b01, 2'b00, 1, 32'h1000, 0, 0);
        vecs[1]  = mk(2'b11, 32'h2000, 1, 0, 0,     2'b10, 2'b00, 1, 32'h2000, 1, 0);
        vecs[2]  = mk(2'b11, 32'h2000, 1, 0, 0,     2'b01, 2'b00, 1, 32'h1000, 0, 0);
        vecs[3]  = mk(2'b11, 32'h2000, 1, 0, 0,     2'b10, 2'b00, 1, 32'h2000, 1, 0);
        // full: stall, then accept alongside a pop
        vecs[4]  = mk(2'b11, 32'h2000, 1, 0, 0,     2'b00, 2'b00, 0, 32'h0,    0, 0);
        vecs[5]  = mk(2'b11, 32'h2000, 1, 1, 32'hA, 2'b01, 2'b01, 1, 32'h1000, 0, 0);
        // drain: FIFO holds 1,0,1,0
        vecs[6]  = mk(2'b00, 32'h2000, 0, 1, 32'hB, 2'b00, 2'b10, 0, 32'h0,    0, 0);
        vecs[7]  = mk(2'b00, 32'h2000, 0, 1, 32'hC, 2'b00, 2'b01, 0, 32'h0,    0, 0);
        vecs[8]  = mk(2'b00, 32'h2000, 0, 1, 32'hD, 2'b00, 2'b10, 0, 32'h0,    0, 0);
        vecs[9]  = mk(2'b00, 32'h2000, 0, 1, 32'hE, 2'b00, 2'b01, 0, 32'h0,    0, 0);
        vecs[10] = mk(2'b00, 32'h2000, 0, 0, 0,     2'b00, 2'b00, 0, 32'h0,    0, 0);
        // routing: IDs 1,0,1 then responses
        vecs[11] = mk(2'b10, 32'h2000, 1, 0, 0,     2'b10, 2'b00, 1, 32'h2000, 1, 0);
        vecs[12] = mk(2'b01, 32'h2000, 1, 0, 0,     2'b01, 2'b00, 1, 32'h1000, 0, 0);
        vecs[13] = mk(2'b10, 32'h2000, 1, 0, 0,     2'b10, 2'b00, 1, 32'h2000, 1, 0);
        vecs[14] = mk(2'b00, 32'h2000, 0, 1, 32'hA, 2'b00, 2'b10, 0, 32'h0,    0, 0);
        vecs[15] = mk(2'b00, 32'h2000, 0, 1, 32'hB, 2'b00, 2'b01, 0, 32'h0,    0, 0);
        vecs[16] = mk(2'b00, 32'h2000, 0, 1, 32'hC, 2'b00, 2'b10, 0, 32'h0,    0, 0);
        // backpressure
        vecs[17] = mk(2'b10, 32'h100,  0, 0, 0,     2'b00, 2'b00, 1, 32'h100,  1, 0);
        vecs[18] = mk(2'b10, 32'h100,  0, 0, 0,     2'b00, 2'b00, 1, 32'h100,  1, 0);
        vecs[19] = mk(2'b10, 32'h100,  0, 0, 0,     2'b00, 2'b00, 1, 32'h100,  1, 0);
        vecs[20] = mk(2'b10, 32'h100,  1, 0, 0,     2'b10, 2'b00, 1, 32'h100,  1, 0);
        vecs[21] = mk(2'b00, 32'h2000, 0, 1, 32'h5, 2'b00, 2'b10, 0, 32'h0,    0, 0);
        // spurious response sets sticky err
        vecs[22] = mk(2'b00, 32'h2000, 0, 1, 32'h7, 2'b00, 2'b00, 0, 32'h0,    0, 0);
        vecs[23] = mk(2'b00, 32'h2000, 0, 0, 0,     2'b00, 2'b00, 0, 32'h0,    0, 1);
        vecs[24] = mk(2'b00, 32'h2000, 0, 0, 0,     2'b00, 2'b00, 0, 32'h0,    0, 1);

        we       = 2'b10;
        wdata    = {32'hBBBB_0001, 32'hAAAA_0000};
        bytemask = 8'hF3;

        // reset held with active inputs
        rst = 1'b0;
        drive(2'b11, 32'h2000, 1, 1, 32'h55);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_gnt",     {30'b0, gnt},    32'h0);
        chk("reset_rvalid",  {30'b0, rvalid}, 32'h0);
        chk("reset_mem_req", {31'b0, mem_req}, 32'h0);
        chk("reset_err",     {31'b0, err},    32'h0);

        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 32'h2000, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].addr1, vecs[i].ready, vecs[i].mrv, vecs[i].mrdata);
            #1;
            chk($sformatf("v%0d_gnt", i),     {30'b0, gnt},     {30'b0, vecs[i].e_gnt});
            chk($sformatf("v%0d_rvalid", i),  {30'b0, rvalid},  {30'b0, vecs[i].e_rvalid});
            chk($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_mreq});
            chk($sformatf("v%0d_mem_addr", i), mem_addr,        vecs[i].e_addr);
            chk($sformatf("v%0d_err", i),     {31'b0, err},     {31'b0, vecs[i].e_err});
            if (vecs[i].e_mreq)
                chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_we});
            if (vecs[i].e_rvalid != 2'b00)
                chk($sformatf("v%0d_rdata", i), rdata, vecs[i].mrdata);
        end

        // two outstanding accepts, then async reset mid-burst
        @(negedge clk);
        drive(2'b11, 32'h2000, 1, 0, 0);
        #1;
        chk("burst_gnt0", {30'b0, gnt}, 32'h1);
        @(negedge clk); #1;
        chk("burst_gnt1", {30'b0, gnt}, 32'h2);
        @(negedge clk);
        drive(2'b11, 32'h2000, 1, 0, 0);
        rst = 1'b0;
        #1;
        chk("midrst_err",     {31'b0, err},     32'h0);
        chk("midrst_gnt",     {30'b0, gnt},     32'h0);
        chk("midrst_mem_req", {31'b0, mem_req}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 32'h2000, 0, 1, 32'h99);
        #1;
        chk("stale_rvalid", {30'b0, rvalid}, 32'h0);
        @(negedge clk);
        drive(2'b11, 32'h2000, 1, 0, 0);
        #1;
        chk("stale_err",      {31'b0, err},  32'h1);
        chk("post_rst_first", {30'b0, gnt},  32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
